lif_timestep_scheduler: RTL and testbench

- Time-multiplexed LIF network controller. One shared leak/integrate/fire datapath serves N neurons, one neuron per cycle, once per externally requested timestep.
- Holds per-neuron membrane and refractory state plus a small runtime-writable configuration register bank.
- Neuron i>0 receives a chained synaptic input from neuron i-1's spike of the previous timestep, giving the same feed-forward chain topology as the existing network.
- Sits between the top-level pin wrapper (tick, currents, config) and the spike outputs.

---
 rtl/lif_timestep_scheduler.sv | 244 ++++++++++++++++++++++++
 tb/tb_lif_timestep_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_timestep_scheduler.sv
// -----------------------------------------------------------------------------
// lif_timestep_scheduler
//
// Time-multiplexed leaky integrate-and-fire controller. A single shared
// leak/integrate/fire datapath visits the N neurons one per cycle, once per
// requested timestep. Neuron i>0 also receives a chained synaptic input when
// neuron i-1 spiked in the previous timestep (feed-forward chain).
//
// Ports
//   clk          clock
//   reset        synchronous, active-high reset
//   tick         timestep request (single-cycle pulse), accepted only when idle
//   in_current   per-neuron unsigned current, neuron i at [i*IW +: IW]
//   cfg_we       configuration write strobe (honoured only when idle)
//   cfg_addr     0 threshold, 1 leak_shift, 2 refr_period, 3 chain_weight
//   cfg_data     configuration write data
//   cfg_ready    high when a configuration write would be accepted
//   busy         a timestep is in progress
//   spike_out    spike vector of the last completed timestep
//   spike_valid  one-cycle pulse while spike_out shows a freshly completed step
//   tick_overrun sticky flag: a tick arrived while busy and was dropped
//   v_mon_sel    neuron select for the membrane monitor (taken modulo N)
//   v_mon        committed membrane potential of the selected neuron
// -----------------------------------------------------------------------------
module lif_timestep_scheduler #(
   parameter int N  = 4,
   parameter int IW = 4,
   parameter int VW = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            tick,
   input  logic [N*IW-1:0] in_current,
   input  logic            cfg_we,
   input  logic [1:0]      cfg_addr,
   input  logic [7:0]      cfg_data,
   output logic            cfg_ready,
   output logic            busy,
   output logic [N-1:0]    spike_out,
   output logic            spike_valid,
   output logic            tick_overrun,
   input  logic [2:0]      v_mon_sel,
   output logic [VW-1:0]   v_mon
);

   localparam int IDXW = $clog2(N);
   // Datapath width: two guard bits so V + current + chain weight cannot wrap.
   localparam int AW   = VW + 2;
   localparam logic [AW-1:0] V_MAX = {2'b00, {VW{1'b1}}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      UPDATE = 2'd1,
      DONE   = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t              state_q,        state_d;
   logic [IDXW-1:0]     idx_q,          idx_d;
   logic [VW-1:0]       v_q    [N];
   logic [VW-1:0]       v_d    [N];
   logic [3:0]          refr_q [N];
   logic [3:0]          refr_d [N];
   logic [N*IW-1:0]     snap_q,         snap_d;
   logic [N-1:0]        shadow_q,       shadow_d;
   logic [N-1:0]        spike_out_q,    spike_out_d;
   logic                spike_valid_q,  spike_valid_d;
   logic                overrun_q,      overrun_d;

   // Configuration bank; only the meaningful low bits of the shift and
   // refractory fields are stored, upper write bits are discarded.
   logic [7:0]          threshold_q,    threshold_d;
   logic [2:0]          leak_shift_q,   leak_shift_d;
   logic [3:0]          refr_period_q,  refr_period_d;
   logic [7:0]          chain_weight_q, chain_weight_d;

   // ---------------------------------------------------------------------------
   // Shared neuron datapath, operating on neuron idx_q
   // ---------------------------------------------------------------------------
   logic [IW-1:0] cur_sel;
   logic [AW-1:0] v_ext;
   logic [AW-1:0] leak;
   logic [AW-1:0] syn;
   logic [AW-1:0] v_sum;
   logic [AW-1:0] v_new;
   logic          in_refr;
   logic          fire;

   always_comb begin
      cur_sel = snap_q[int'(idx_q)*IW +: IW];
      v_ext   = AW'(v_q[idx_q]);
      in_refr = (refr_q[idx_q] != 4'd0);

      leak = (leak_shift_q == 3'd0) ? '0 : (v_ext >> leak_shift_q);

      // Chain input comes from the previous timestep's registered spikes, which
      // stay untouched until the whole sweep has finished.
      syn = '0;
      if (idx_q != '0 && spike_out_q[idx_q - 1'b1]) begin
         syn = AW'(chain_weight_q);
      end

      // leak <= V, so the subtraction never underflows.
      v_sum = v_ext - leak + AW'(cur_sel) + syn;
      v_new = (v_sum > V_MAX) ? V_MAX : v_sum;
      fire  = (v_new >= AW'(threshold_q));
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every variable gets its hold value before any branch, so no path
   // through this block leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      v_d            = v_q;
      refr_d         = refr_q;
      snap_d         = snap_q;
      shadow_d       = shadow_q;
      spike_out_d    = spike_out_q;
      spike_valid_d  = 1'b0;
      overrun_d      = overrun_q;
      threshold_d    = threshold_q;
      leak_shift_d   = leak_shift_q;
      refr_period_d  = refr_period_q;
      chain_weight_d = chain_weight_q;

      // Configuration lands at the same edge as an accepted tick, so that
      // timestep already sees the new value.
      if (cfg_we && state_q == IDLE) begin
         unique case (cfg_addr)
            2'd0:    threshold_d    = cfg_data;
            2'd1:    leak_shift_d   = cfg_data[2:0];
            2'd2:    refr_period_d  = cfg_data[3:0];
            default: chain_weight_d = cfg_data;
         endcase
      end

      unique case (state_q)
         IDLE: begin
            if (tick) begin
               snap_d  = in_current;
               idx_d   = '0;
               state_d = UPDATE;
            end
         end

         UPDATE: begin
            if (in_refr) begin
               refr_d[idx_q]   = refr_q[idx_q] - 4'd1;
               v_d[idx_q]      = '0;
               shadow_d[idx_q] = 1'b0;
            end else if (fire) begin
               refr_d[idx_q]   = refr_period_q;
               v_d[idx_q]      = '0;
               shadow_d[idx_q] = 1'b1;
            end else begin
               v_d[idx_q]      = v_new[VW-1:0];
               shadow_d[idx_q] = 1'b0;
            end

            if (idx_q == IDXW'(N - 1)) begin
               // The spike vector is loaded on the edge into DONE so it is
               // already visible while spike_valid is high during DONE.
               // shadow_d here already includes the last neuron's spike.
               state_d       = DONE;
               spike_out_d   = shadow_d;
               spike_valid_d = 1'b1;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (tick && state_q != IDLE) begin
         overrun_d = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of its source regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         idx_q          <= '0;
         // NOTE: the per-neuron state is a small flop array rather than a RAM,
         // and the neuron model requires V and refractory counts to start at
         // zero, so it is cleared with the rest of the state.
         v_q            <= '{default: '0};
         refr_q         <= '{default: '0};
         snap_q         <= '0;
         shadow_q       <= '0;
         spike_out_q    <= '0;
         spike_valid_q  <= 1'b0;
         overrun_q      <= 1'b0;
         threshold_q    <= 8'd100;
         leak_shift_q   <= 3'd2;
         refr_period_q  <= 4'd2;
         chain_weight_q <= 8'd40;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         v_q            <= v_d;
         refr_q         <= refr_d;
         snap_q         <= snap_d;
         shadow_q       <= shadow_d;
         spike_out_q    <= spike_out_d;
         spike_valid_q  <= spike_valid_d;
         overrun_q      <= overrun_d;
         threshold_q    <= threshold_d;
         leak_shift_q   <= leak_shift_d;
         refr_period_q  <= refr_period_d;
         chain_weight_q <= chain_weight_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   logic [IDXW-1:0] mon_idx;

   assign mon_idx      = IDXW'(int'(v_mon_sel) % N);
   assign v_mon        = v_q[mon_idx];
   assign busy         = (state_q != IDLE);
   assign cfg_ready    = ~busy;
   assign spike_out    = spike_out_q;
   assign spike_valid  = spike_valid_q;
   assign tick_overrun = overrun_q;

endmodule

// File: tb/tb_lif_timestep_scheduler.sv
// -----------------------------------------------------------------------------
// tb_lif_timestep_scheduler
//
// Self-checking bench for lif_timestep_scheduler (N=4, IW=4, VW=8). A
// behavioural model tracks every neuron's V and refractory count with plain
// integer arithmetic, one whole timestep at a time; the bench compares the
// DUT's spikes, membrane monitor, handshake timing and flags against it.
// -----------------------------------------------------------------------------
module tb_lif_timestep_scheduler;

   localparam int N  = 4;
   localparam int IW = 4;
   localparam int VW = 8;
   localparam int V_MAX = (1 << VW) - 1;

   logic            clk = 1'b0;
   logic            reset;
   logic            tick;
   logic [N*IW-1:0] in_current;
   logic            cfg_we;
   logic [1:0]      cfg_addr;
   logic [7:0]      cfg_data;
   logic            cfg_ready;
   logic            busy;
   logic [N-1:0]    spike_out;
   logic            spike_valid;
   logic            tick_overrun;
   logic [2:0]      v_mon_sel;
   logic [VW-1:0]   v_mon;

   always #5 clk = ~clk;

   lif_timestep_scheduler #(.N(N), .IW(IW), .VW(VW)) dut (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .in_current   (in_current),
      .cfg_we       (cfg_we),
      .cfg_addr     (cfg_addr),
      .cfg_data     (cfg_data),
      .cfg_ready    (cfg_ready),
      .busy         (busy),
      .spike_out    (spike_out),
      .spike_valid  (spike_valid),
      .tick_overrun (tick_overrun),
      .v_mon_sel    (v_mon_sel),
      .v_mon        (v_mon)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   int         mv [N];
   int         mr [N];
   bit [N-1:0] m_spk;
   int         m_thr, m_ls, m_rp, m_cw;
   bit         m_ovr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mv[i] = 0;
         mr[i] = 0;
      end
      m_spk = '0;
      m_thr = 100;
      m_ls  = 2;
      m_rp  = 2;
      m_cw  = 40;
      m_ovr = 1'b0;
   endtask

   task automatic model_cfg(input logic [1:0] addr, input logic [7:0] data);
      case (addr)
         2'd0:    m_thr = int'(data);
         2'd1:    m_ls  = int'(data) % 8;
         2'd2:    m_rp  = int'(data) % 16;
         default: m_cw  = int'(data);
      endcase
   endtask

   // One full timestep: every neuron sees the previous timestep's spike vector.
   task automatic model_step(input logic [N*IW-1:0] cur);
      bit [N-1:0] ns = '0;
      for (int i = 0; i < N; i++) begin
         if (mr[i] > 0) begin
            mr[i] = mr[i] - 1;
            mv[i] = 0;
         end else begin
            int leak = (m_ls == 0) ? 0 : (mv[i] >> m_ls);
            int syn  = (i > 0 && m_spk[i-1]) ? m_cw : 0;
            int vn   = mv[i] - leak + int'(cur[i*IW +: IW]) + syn;
            if (vn > V_MAX) vn = V_MAX;
            if (vn >= m_thr) begin
               ns[i] = 1'b1;
               mv[i] = 0;
               mr[i] = m_rp;
            end else begin
               mv[i] = vn;
            end
         end
      end
      m_spk = ns;
   endtask

   function automatic logic [N*IW-1:0] cur_n0(input int v);
      return (N*IW)'(v);
   endfunction

   function automatic logic [N*IW-1:0] cur_all(input int v);
      logic [N*IW-1:0] c = '0;
      for (int i = 0; i < N; i++) c[i*IW +: IW] = IW'(v);
      return c;
   endfunction

   function automatic logic [N*IW-1:0] cur_rand();
      logic [N*IW-1:0] c = '0;
      for (int i = 0; i < N; i++) c[i*IW +: IW] = IW'($urandom_range(0, (1 << IW) - 1));
      return c;
   endfunction

   task automatic check_vs(input string tag);
      for (int i = 0; i < N; i++) begin
         v_mon_sel = 3'(i);
         #1;
         check($sformatf("%s_v%0d", tag, i), 32'(v_mon), mv[i]);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic cfg(input logic [1:0] addr, input logic [7:0] data);
      cfg_we   = 1'b1;
      cfg_addr = addr;
      cfg_data = data;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      model_cfg(addr, data);
   endtask

   // Issue one timestep and follow it for N+3 cycles.
   //   tcfg/taddr/tdata : config write in the same cycle as the tick
   //   xtick_at         : cycle offset (1..N+1) of an extra tick while busy, 0 = none
   //   bcfg_at/bdata    : cycle offset of a threshold write while busy, 0 = none
   task automatic run_ts(input logic [N*IW-1:0] cur, input string tag,
                         input bit tcfg, input logic [1:0] taddr, input logic [7:0] tdata,
                         input int xtick_at, input int bcfg_at, input logic [7:0] bdata);
      int           sv_cycle = -1;
      int           sv_count = 0;
      logic [N-1:0] sv_spk   = '0;
      in_current = cur;
      tick       = 1'b1;
      if (tcfg) begin
         cfg_we   = 1'b1;
         cfg_addr = taddr;
         cfg_data = tdata;
         model_cfg(taddr, tdata);
      end
      @(posedge clk); #1;
      tick   = 1'b0;
      cfg_we = 1'b0;
      model_step(cur);
      for (int c = 1; c <= N + 3; c++) begin
         if (c == xtick_at) begin
            tick  = 1'b1;
            m_ovr = 1'b1;
         end
         if (c == bcfg_at) begin
            cfg_we   = 1'b1;
            cfg_addr = 2'd0;
            cfg_data = bdata;
         end
         check({tag, "_busy"}, 32'(busy), 32'(c <= N + 1));
         if (spike_valid) begin
            sv_count++;
            if (sv_cycle < 0) begin
               sv_cycle = c;
               sv_spk   = spike_out;
            end
         end
         @(posedge clk); #1;
         tick   = 1'b0;
         cfg_we = 1'b0;
      end
      check({tag, "_valid_cycle"}, sv_cycle, N + 1);
      check({tag, "_valid_count"}, sv_count, 1);
      check({tag, "_spk_at_valid"}, 32'(sv_spk), 32'(m_spk));
      check({tag, "_spk_held"}, 32'(spike_out), 32'(m_spk));
      check({tag, "_overrun"}, 32'(tick_overrun), 32'(m_ovr));
      check_vs(tag);
   endtask

   task automatic plain_ts(input logic [N*IW-1:0] cur, input string tag);
      run_ts(cur, tag, 1'b0, 2'd0, 8'd0, 0, 0, 8'd0);
   endtask

   task automatic v0_is(input string tag, input int exp);
      v_mon_sel = 3'd0;
      #1;
      check(tag, 32'(v_mon), exp);
   endtask

   initial begin
      reset      = 1'b1;
      tick       = 1'b0;
      cfg_we     = 1'b0;
      cfg_addr   = 2'd0;
      cfg_data   = 8'd0;
      in_current = '0;
      v_mon_sel  = 3'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state
      check("rst_busy", 32'(busy), 0);
      check("rst_cfg_ready", 32'(cfg_ready), 1);
      check("rst_spike_out", 32'(spike_out), 0);
      check("rst_spike_valid", 32'(spike_valid), 0);
      check("rst_overrun", 32'(tick_overrun), 0);
      check_vs("rst");

      // Zero-current timestep: timing and idle result
      plain_ts('0, "zero");

      // Feed-forward chain
      do_reset();
      cfg(2'd1, 8'd0);
      cfg(2'd0, 8'd100);
      cfg(2'd3, 8'd100);
      cfg(2'd2, 8'd0);
      for (int t = 1; t <= 10; t++) begin
         plain_ts(cur_n0(15), $sformatf("chain%0d", t));
         if (t >= 7) check($sformatf("chain%0d_dir", t), 32'(spike_out), 32'(1 << (t - 7)));
         if (t == 7) v0_is("chain7_v0", 0);
         if (t == 8) v0_is("chain8_v0", 15);
      end

      // Monitor select wraps modulo N
      v_mon_sel = 3'(N + 1);
      #1;
      check("mon_wrap", 32'(v_mon), mv[1]);

      // Refractory behaviour
      do_reset();
      cfg(2'd1, 8'd0);
      cfg(2'd0, 8'd20);
      cfg(2'd2, 8'd2);
      for (int t = 1; t <= 10; t++) begin
         plain_ts(cur_n0(10), $sformatf("refr%0d", t));
         if (t == 3 || t == 4) v0_is($sformatf("refr%0d_v0_zero", t), 0);
      end

      // Saturation
      do_reset();
      cfg(2'd1, 8'd0);
      cfg(2'd0, 8'd255);
      cfg(2'd2, 8'd0);
      for (int t = 1; t <= 17; t++) begin
         plain_ts(cur_n0(15), $sformatf("sat%0d", t));
         if (t == 16) v0_is("sat16_v0", 240);
         if (t == 17) begin
            check("sat17_spk0", 32'(spike_out[0]), 1);
            v0_is("sat17_v0", 0);
         end
      end

      // Ticks while busy are dropped and set the sticky overrun flag
      do_reset();
      run_ts(cur_rand(), "ovr_upd", 1'b0, 2'd0, 8'd0, 2, 0, 8'd0);
      plain_ts(cur_rand(), "ovr_sticky");
      run_ts(cur_rand(), "ovr_done", 1'b0, 2'd0, 8'd0, N + 1, 0, 8'd0);
      do_reset();
      check("ovr_cleared", 32'(tick_overrun), 0);

      // Config write while busy is ignored; write together with tick applies
      run_ts(cur_all(9), "cfg_busy", 1'b0, 2'd0, 8'd0, 0, 2, 8'd5);
      check("cfg_busy_nofire", 32'(spike_out), 0);
      run_ts(cur_all(10), "cfg_tick", 1'b1, 2'd0, 8'd5, 0, 0, 8'd0);
      check("cfg_tick_fire", 32'(spike_out), 32'((1 << N) - 1));

      // Reset in the middle of a timestep aborts it
      do_reset();
      plain_ts(cur_all(7), "pre_abort");
      in_current = cur_rand();
      tick       = 1'b1;
      @(posedge clk); #1;          // cycle T+1
      tick = 1'b0;
      @(posedge clk); #1;          // cycle T+2
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      begin
         int sv_seen = 0;
         check("abort_busy", 32'(busy), 0);
         check("abort_spike_out", 32'(spike_out), 0);
         check("abort_overrun", 32'(tick_overrun), 0);
         check_vs("abort");
         for (int c = 0; c < N + 3; c++) begin
            if (spike_valid) sv_seen++;
            @(posedge clk); #1;
         end
         check("abort_no_valid", sv_seen, 0);
      end
      // Defaults restored: a timestep with the reset-time config
      plain_ts(cur_all(15), "post_abort");

      // Randomised timesteps with occasional idle config writes
      do_reset();
      cfg(2'd0, 8'd0);
      plain_ts(cur_rand(), "thr0_a");
      plain_ts(cur_rand(), "thr0_b");
      cfg(2'd0, 8'd60);
      for (int k = 0; k < 30; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            logic [1:0] a = 2'($urandom_range(0, 3));
            logic [7:0] d = 8'($urandom_range(0, 255));
            if (a == 2'd0 && d < 8'd20) d = d + 8'd20;
            cfg(a, d);
         end
         plain_ts(cur_rand(), $sformatf("rnd%0d", k));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
